// File: rtl/bus_master_pkg.sv
// Shared definitions for the bus initiator and the responders on the 8-bit system bus.
package bus_master_pkg;

   localparam int BM_DATA_WIDTH   = 8;
   localparam int BM_ADDR_WIDTH   = 8;
   localparam int BM_LEN_WIDTH    = 4;
   // Read latency the data RAM is built with; the initiator must agree.
   localparam int BM_READ_LATENCY = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_DRAIN,
      ST_TURN
   } bm_state_e;

endpackage

// File: rtl/bus_rd_pipe.sv
// Tracks outstanding read addresses: one valid/last bit per bus cycle of read latency.
module bus_rd_pipe
   import bus_master_pkg::*;
#(
   parameter int LATENCY = BM_READ_LATENCY
) (
   input  logic CLK,
   input  logic RESET_N,
   input  logic issue_i,
   input  logic last_i,
   output logic exit_valid_o,
   output logic exit_last_o,
   output logic empty_o
);

   logic [LATENCY-1:0] valid_q;
   logic [LATENCY-1:0] last_q;

   // Stage 0 is loaded on the same edge that puts the address on the bus.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         valid_q <= '0;
         last_q  <= '0;
      end else begin
         valid_q[0] <= issue_i;
         last_q[0]  <= issue_i & last_i;
         for (int i = 1; i < LATENCY; i++) begin
            valid_q[i] <= valid_q[i-1];
            last_q[i]  <= last_q[i-1];
         end
      end
   end

   assign exit_valid_o = valid_q[LATENCY-1];
   assign exit_last_o  = last_q[LATENCY-1];
   assign empty_o      = ~|valid_q;

endmodule

// File: rtl/bus_master.sv
// Bus initiator: runs single/burst read and write commands on BUS_ADDR/BUS_WE/BUS_DATA.
module bus_master
   import bus_master_pkg::*;
#(
   parameter int DATA_WIDTH   = BM_DATA_WIDTH,
   parameter int ADDR_WIDTH   = BM_ADDR_WIDTH,
   parameter int READ_LATENCY = BM_READ_LATENCY,
   parameter int LEN_WIDTH    = BM_LEN_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic                  CMD_VALID,
   output logic                  CMD_READY,
   input  logic                  CMD_WE,
   input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
   input  logic [LEN_WIDTH-1:0]  CMD_LEN,
   input  logic                  WR_VALID,
   output logic                  WR_READY,
   input  logic [DATA_WIDTH-1:0] WR_DATA,
   output logic                  RD_VALID,
   output logic [DATA_WIDTH-1:0] RD_DATA,
   output logic                  RD_LAST,
   output logic                  BUSY,
   output logic [ADDR_WIDTH-1:0] BUS_ADDR,
   output logic                  BUS_WE,
   inout  wire  [DATA_WIDTH-1:0] BUS_DATA
);

   bm_state_e             state_q,     state_d;
   logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
   logic [LEN_WIDTH-1:0]  len_q,       len_d;
   logic [LEN_WIDTH-1:0]  cnt_q,       cnt_d;
   logic                  wdone_q,     wdone_d;
   logic [ADDR_WIDTH-1:0] bus_addr_q,  bus_addr_d;
   logic                  bus_we_q,    bus_we_d;
   logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
   logic                  rd_valid_q;
   logic                  rd_last_q;
   logic [DATA_WIDTH-1:0] rd_data_q;

   logic accept;
   logic wr_ready;
   logic issue;
   logic issue_last;
   logic exit_valid;
   logic exit_last;
   logic pipe_empty;

   assign CMD_READY = (state_q == ST_IDLE) && RESET_N;
   assign accept    = CMD_VALID && CMD_READY;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      wdone_d     = wdone_q;
      bus_addr_d  = bus_addr_q;
      bus_we_d    = 1'b0;
      bus_wdata_d = bus_wdata_q;
      wr_ready    = 1'b0;
      issue       = 1'b0;
      issue_last  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               addr_d  = CMD_ADDR;
               len_d   = CMD_LEN;
               cnt_d   = '0;
               wdone_d = 1'b0;
               state_d = CMD_WE ? ST_WRITE : ST_READ;
            end
         end
         ST_WRITE: begin
            // The last beat spends one more cycle on the bus before the turnaround cycle.
            if (wdone_q) begin
               state_d = ST_TURN;
            end else begin
               wr_ready = 1'b1;
               if (WR_VALID) begin
                  bus_addr_d  = addr_q;
                  bus_we_d    = 1'b1;
                  bus_wdata_d = WR_DATA;
                  addr_d      = addr_q + ADDR_WIDTH'(1);
                  if (cnt_q == len_q) begin
                     wdone_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q + LEN_WIDTH'(1);
                  end
               end
            end
         end
         ST_READ: begin
            bus_addr_d = addr_q;
            issue      = 1'b1;
            addr_d     = addr_q + ADDR_WIDTH'(1);
            if (cnt_q == len_q) begin
               issue_last = 1'b1;
               state_d    = ST_DRAIN;
            end else begin
               cnt_d = cnt_q + LEN_WIDTH'(1);
            end
         end
         ST_DRAIN: begin
            if (pipe_empty) begin
               state_d = ST_TURN;
            end
         end
         ST_TURN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         wdone_q     <= 1'b0;
         bus_addr_q  <= '0;
         bus_we_q    <= 1'b0;
         bus_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         wdone_q     <= wdone_d;
         bus_addr_q  <= bus_addr_d;
         bus_we_q    <= bus_we_d;
         bus_wdata_q <= bus_wdata_d;
      end
   end

   bus_rd_pipe #(
      .LATENCY (READ_LATENCY)
   ) u_rd_pipe (
      .CLK          (CLK),
      .RESET_N      (RESET_N),
      .issue_i      (issue),
      .last_i       (issue_last),
      .exit_valid_o (exit_valid),
      .exit_last_o  (exit_last),
      .empty_o      (pipe_empty)
   );

   // Read data is taken off the bus on the edge the tracking bit leaves the pipe.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= exit_valid;
         rd_last_q  <= exit_valid & exit_last;
         if (exit_valid) begin
            rd_data_q <= BUS_DATA;
         end
      end
   end

   assign WR_READY = wr_ready;
   assign RD_VALID = rd_valid_q;
   assign RD_LAST  = rd_last_q;
   assign RD_DATA  = rd_data_q;
   assign BUSY     = (state_q != ST_IDLE);
   assign BUS_ADDR = bus_addr_q;
   assign BUS_WE   = bus_we_q;
   assign BUS_DATA = bus_we_q ? bus_wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: doc/bus_master.md
# bus_master

Initiator for the shared 8-bit system bus: accepts single or burst read/write commands on a valid/ready command port and executes them against bus responders, e.g. the data RAM, on BUS_ADDR / BUS_WE / BUS_DATA. It is the block that drives the address, write-enable and write data, and captures read data, replacing hand-driven bus stimulus wherever a controller needs memory access. It sits between a command source (processor, DMA-style engine or test sequencer) and the bus.

## Interface
- DATA_WIDTH, 8, bus data width
- ADDR_WIDTH, 8, bus address width
- READ_LATENCY, 2, cycles from an address appearing on BUS_ADDR to its data being valid on BUS_DATA (range 1–4)
- LEN_WIDTH, 4, burst length field width; beats = CMD_LEN+1 (1–16)

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- CMD_VALID  in  1  command present
- CMD_READY  out  1  block can accept a command
- CMD_WE  in  1  1 = write burst, 0 = read burst
- CMD_ADDR  in  ADDR_WIDTH  start address
- CMD_LEN  in  LEN_WIDTH  beats minus one
- WR_VALID  in  1  write beat data present
- WR_READY  out  1  write beat accepted this cycle
- WR_DATA  in  DATA_WIDTH  write beat data
- RD_VALID  out  1  read beat valid (no backpressure; consumer must take it)
- RD_DATA  out  DATA_WIDTH  read beat data
- RD_LAST  out  1  final beat of read burst
- BUSY  out  1  state ≠ IDLE
- BUS_ADDR  out  ADDR_WIDTH  registered bus address
- BUS_WE  out  1  registered bus write enable
- BUS_DATA  inout  DATA_WIDTH  driven only while BUS_WE=1, else high-Z

## Operation
- States: IDLE, WRITE, READ, DRAIN, TURN.
- IDLE: CMD_READY=1. On CMD_VALID&&CMD_READY latch WE/ADDR/LEN, beat counter=0; go WRITE or READ.
- WRITE: WR_READY=1. Each edge with WR_VALID: register BUS_ADDR=addr, BUS_WE=1, data=WR_DATA; addr+1, count+1. Edge without WR_VALID: BUS_WE=0 next cycle (bubble; address held). After last beat accepted → TURN.
- READ: one address per cycle, BUS_WE=0, LEN+1 consecutive cycles, address incrementing; then → DRAIN.
- DRAIN: wait until the read-valid pipeline is empty → TURN.
- TURN: one cycle, BUS_WE=0, BUS_DATA released; → IDLE. Guarantees one dead cycle between any two commands (bus turnaround).
- Address arithmetic modulo 2^ADDR_WIDTH: 8'hFF + 1 → 8'h00, no error.
- Read capture: a valid/last shift register of depth READ_LATENCY tracks each issued read address; when the bit exits, RD_DATA is sampled from BUS_DATA and RD_VALID pulses for one cycle, with RD_LAST on the final beat.
- CMD_VALID while BUSY: ignored, held off by CMD_READY=0.

## Timing
- Reset (asynchronous, immediate): state IDLE, BUS_ADDR=0, BUS_WE=0, BUS_DATA high-Z, WR_READY=0, RD_VALID=0, RD_LAST=0, RD_DATA=0, BUSY=0, CMD_READY=0 while RESET_N low.
- Reset mid-burst: burst aborted, bus released within the same cycle, no further RD_VALID, no write completes after RESET_N falls.
- Command accepted at edge N: first beat on bus in cycle N+1 (read), or beat at edge N+1 at the earliest (write).
- Read: address in cycle c → RD_VALID in cycle c+READ_LATENCY. Burst of B beats with no bubbles: RD_VALID high for B consecutive cycles.
- Read command latency from accept to CMD_READY: B+READ_LATENCY+2 cycles.
- Write with WR_VALID constantly high: B+2 cycles from accept to CMD_READY.

## Structure
- Shared package bus_master_pkg: state enum (IDLE/WRITE/READ/DRAIN/TURN), bus width constants, and default READ_LATENCY shared with the RAM.
- One sub-module: bus_rd_pipe, the READ_LATENCY-deep valid/last shift register with async active-low reset, producing capture strobe and RD_LAST.

## Test plan
- Write single: ADDR=8'h03, WR_DATA=8'h09, LEN=0 → BUS_WE=1 and BUS_DATA=8'h09 at BUS_ADDR=8'h03 for exactly one cycle, then one TURN cycle with BUS_DATA high-Z; a subsequent read of 8'h03 returns RD_DATA=8'h09 with RD_LAST=1.
- Write burst LEN=3 at 8'h10 with data 8'hA0–8'hA3, WR_VALID low for 2 cycles after beat 1 → BUS_WE bubble of 2 cycles, address held at 8'h11; the RAM holds A0–A3 at 10–13.
- Read burst LEN=3 from 8'h10 → RD_VALID for 4 consecutive cycles starting READ_LATENCY cycles after the first address, data A0,A1,A2,A3, RD_LAST only on A3.
- Wrap-around: write LEN=1 at 8'hFF → beats land at 8'hFF then 8'h00.
- Back-to-back: a read command presented the cycle after a write completes → CMD_READY low through TURN, never both master and RAM driving BUS_DATA (no X on the bus).
- Reset mid-read (RESET_N low during beat 2 of LEN=7) → outputs return to reset values the same cycle, no RD_VALID afterwards, CMD_READY=1 one cycle after release.
